// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_pkg
//  Description : Shared types and constants for the program loader: FSM
//                state encoding, default word/address widths, memory depth
//                and stream byte width.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int DATA      = 32;
    localparam int ADDR      = 6;
    localparam int MAX_WORDS = 64;
    localparam int BYTE_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_WAITW = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_if
//  Description : Byte-stream input and instruction-memory write bus of the
//                program loader. The slave modport is the loader side, the
//                master modport is the host / memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int DATA = prog_loader_pkg::DATA,
    parameter int ADDR = prog_loader_pkg::ADDR
);

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR-1:0]   im_addr;
    logic [DATA-1:0]   im_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

endinterface
`default_nettype wire

// File: rtl/prog_loader_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : word_packer
//  Description : Packs stream bytes MSB first into instruction words. The
//                first three bytes sit in a shift register; word/word_valid
//                present the completed word combinationally in the cycle the
//                fourth byte is accepted so the caller can register it.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_packer
    import prog_loader_pkg::*;
#(
    parameter int DATA = prog_loader_pkg::DATA
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              byte_valid,
    input  wire logic [BYTE_W-1:0] byte_in,
    output logic      [DATA-1:0]   word,
    output logic                   word_valid
);

    logic [DATA-BYTE_W-1:0] shift;
    logic [1:0]             cnt;

    assign word       = {shift, byte_in};
    assign word_valid = byte_valid && (cnt == 2'd3);

    // Shift in accepted bytes; clear drops any partial word at a new load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shift <= '0;
            cnt   <= '0;
        end else if (byte_valid) begin
            shift <= word[DATA-BYTE_W-1:0];
            cnt   <= cnt + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Boot loader. Receives a header byte (word count N), N*4
//                data bytes and an XOR checksum byte, writes each assembled
//                word into instruction memory and releases the CPU once the
//                checksum matches.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA = prog_loader_pkg::DATA,
    parameter int ADDR = prog_loader_pkg::ADDR
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   start,
    prog_loader_if.slave bus,
    output logic        cpu_run,
    output logic        load_done,
    output logic        load_err
);

    localparam int               CNT_W   = $clog2(MAX_WORDS) + 1;
    localparam logic [BYTE_W-1:0] MAX_HDR = BYTE_W'(MAX_WORDS);

    state_t              state;
    logic [CNT_W-1:0]    n_words;
    logic [CNT_W-1:0]    word_cnt;
    logic [BYTE_W-1:0]   csum;

    logic                start_ok;
    logic                accept;
    logic                data_byte;
    logic [DATA-1:0]     word;
    logic                word_valid;

    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign accept    = bus.in_valid && bus.in_ready;
    assign data_byte = accept && (state == S_DATA);

    word_packer #(
        .DATA (DATA)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_valid (data_byte),
        .byte_in    (bus.in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Load sequencer: state, counters, checksum and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            n_words      <= '0;
            word_cnt     <= '0;
            csum         <= '0;
            bus.in_ready <= 1'b0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
            cpu_run      <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            bus.im_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_ok) begin
                        state        <= S_HDR;
                        n_words      <= '0;
                        word_cnt     <= '0;
                        csum         <= '0;
                        bus.in_ready <= 1'b1;
                        cpu_run      <= 1'b0;
                        load_done    <= 1'b0;
                        load_err     <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        csum    <= bus.in_data;
                        n_words <= bus.in_data[CNT_W-1:0];
                        if (bus.in_data == '0) begin
                            state <= S_CSUM;
                        end else if (bus.in_data > MAX_HDR) begin
                            state        <= S_ERR;
                            bus.in_ready <= 1'b0;
                            load_err     <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum <= csum ^ bus.in_data;
                        if (word_valid) begin
                            bus.im_we    <= 1'b1;
                            bus.im_addr  <= word_cnt[ADDR-1:0];
                            bus.im_wdata <= word;
                            word_cnt     <= word_cnt + CNT_W'(1);
                            // Leave DATA on the last byte so the checksum
                            // byte can follow back to back.
                            if (word_cnt + CNT_W'(1) == n_words) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        bus.in_ready <= 1'b0;
                        if (bus.in_data == csum) begin
                            state <= S_WAITW;
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                S_WAITW: begin
                    // One spare cycle lets the final write land before release.
                    state     <= S_DONE;
                    cpu_run   <= 1'b1;
                    load_done <= 1'b1;
                end
                default: begin
                    state        <= S_IDLE;
                    bus.in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Directed self-checking bench for prog_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic cpu_run;
    logic load_done;
    logic load_err;

    prog_loader_if #(.DATA(32), .ADDR(6)) bus ();

    prog_loader #(.DATA(32), .ADDR(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Record every instruction-memory write.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            wr_addr_q.push_back(bus.im_addr);
            wr_data_q.push_back(bus.im_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        logic [41:0] got;
        #3;
        got = {bus.in_ready, bus.im_we, cpu_run, load_done, load_err, bus.im_addr, bus.im_wdata};
        n_checks++;
        if (got !== 42'd0) $display("FAIL reset_outputs: got %h expected 0", got);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({bus.in_ready, cpu_run, bus.im_we} !== 3'b000)
            $display("FAIL idle_after_reset: got %b expected 000", {bus.in_ready, cpu_run, bus.im_we});
        else n_pass++;
    endtask

    task automatic test_single_word();
        clear_log();
        pulse_start();
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL hdr_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        n_checks++;
        if ({bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 6'd0, 32'hAABBCCDD})
            $display("FAIL single_write: got we=%b addr=%0d data=%h expected we=1 addr=0 data=aabbccdd",
                     bus.im_we, bus.im_addr, bus.im_wdata);
        else n_pass++;
        send_byte(8'h01);
        n_checks++;
        if ({cpu_run, bus.in_ready, bus.im_we} !== 3'b000)
            $display("FAIL waitw_cycle: got run/ready/we=%b expected 000", {cpu_run, bus.in_ready, bus.im_we});
        else n_pass++;
        tick();
        n_checks++;
        if ({cpu_run, load_done, load_err} !== 3'b110)
            $display("FAIL single_done: got run/done/err=%b expected 110", {cpu_run, load_done, load_err});
        else n_pass++;
        n_checks++;
        if (wr_addr_q.size() !== 1) $display("FAIL single_write_count: got %0d expected 1", wr_addr_q.size());
        else n_pass++;
    endtask

    task automatic test_gapped();
        logic [7:0]  bytes [0:12];
        logic [31:0] exp_data [0:2];
        bytes = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'hAA, 8'hBB, 8'hCC};
        exp_data = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        clear_log();
        pulse_start();
        for (int i = 0; i < 13; i++) begin
            send_byte(bytes[i]);
            repeat (5) tick();
        end
        n_checks++;
        if ({bus.in_ready, cpu_run} !== 2'b10)
            $display("FAIL gap_stall: got ready/run=%b expected 10", {bus.in_ready, cpu_run});
        else n_pass++;
        send_byte(8'hCF);
        tick();
        n_checks++;
        if ({cpu_run, load_done, load_err} !== 3'b110)
            $display("FAIL gap_done: got run/done/err=%b expected 110", {cpu_run, load_done, load_err});
        else n_pass++;
        n_checks++;
        if (wr_addr_q.size() !== 3) $display("FAIL gap_write_count: got %0d expected 3", wr_addr_q.size());
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            logic [5:0]  ga;
            logic [31:0] gd;
            ga = (i < wr_addr_q.size()) ? wr_addr_q[i] : 6'bx;
            gd = (i < wr_data_q.size()) ? wr_data_q[i] : 32'bx;
            n_checks++;
            if ({ga, gd} !== {6'(i), exp_data[i]})
                $display("FAIL gap_write_%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                         i, ga, gd, i, exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_bad_csum();
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        send_byte(8'h00);
        n_checks++;
        if ({load_err, cpu_run, load_done, bus.in_ready} !== 4'b1000)
            $display("FAIL bad_csum_err: got err/run/done/ready=%b expected 1000",
                     {load_err, cpu_run, load_done, bus.in_ready});
        else n_pass++;
        tick();
        n_checks++;
        if (wr_data_q.size() !== 1 || wr_data_q[0] !== 32'h12345678)
            $display("FAIL bad_csum_write: got count=%0d expected 1 write of 12345678", wr_data_q.size());
        else n_pass++;
    endtask

    task automatic test_oversize();
        clear_log();
        pulse_start();
        n_checks++;
        if (load_err !== 1'b0) $display("FAIL restart_clears_err: got %b expected 0", load_err);
        else n_pass++;
        send_byte(8'h41);
        n_checks++;
        if ({load_err, bus.in_ready, cpu_run} !== 3'b100)
            $display("FAIL oversize_err: got err/ready/run=%b expected 100", {load_err, bus.in_ready, cpu_run});
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (wr_addr_q.size() !== 0) $display("FAIL oversize_no_write: got %0d expected 0", wr_addr_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        logic [41:0] got;
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b0;
        #1;
        got = {bus.in_ready, bus.im_we, cpu_run, load_done, load_err, bus.im_addr, bus.im_wdata};
        n_checks++;
        if (got !== 42'd0) $display("FAIL midword_reset_outputs: got %h expected 0", got);
        else n_pass++;
        tick();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({bus.in_ready, cpu_run} !== 2'b00)
            $display("FAIL midword_idle: got ready/run=%b expected 00", {bus.in_ready, cpu_run});
        else n_pass++;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hBA);
        send_byte(8'hBE);
        send_byte(8'h31);
        tick();
        n_checks++;
        if (load_done !== 1'b1) $display("FAIL midword_done: got %b expected 1", load_done);
        else n_pass++;
        n_checks++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 32'hCAFEBABE)
            $display("FAIL midword_write: got count=%0d expected one write addr 0 data cafebabe",
                     wr_addr_q.size());
        else n_pass++;
    endtask

    task automatic test_empty_restart();
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        tick();
        n_checks++;
        if ({cpu_run, load_done, load_err} !== 3'b110)
            $display("FAIL empty_done: got run/done/err=%b expected 110", {cpu_run, load_done, load_err});
        else n_pass++;
        n_checks++;
        if (wr_addr_q.size() !== 0) $display("FAIL empty_no_write: got %0d expected 0", wr_addr_q.size());
        else n_pass++;
        pulse_start();
        n_checks++;
        if ({cpu_run, load_done, bus.in_ready} !== 3'b001)
            $display("FAIL restart_clear: got run/done/ready=%b expected 001", {cpu_run, load_done, bus.in_ready});
        else n_pass++;
    endtask

    // Continues from the HDR state left by test_empty_restart.
    task automatic test_start_ignored();
        clear_log();
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h06);
        pulse_start();
        send_byte(8'h07);
        send_byte(8'h08);
        send_byte(8'h0A);
        tick();
        n_checks++;
        if ({load_done, load_err} !== 2'b10)
            $display("FAIL ignore_start_done: got done/err=%b expected 10", {load_done, load_err});
        else n_pass++;
        n_checks++;
        if (wr_data_q.size() !== 2 || wr_data_q[0] !== 32'h01020304 || wr_data_q[1] !== 32'h05060708
            || wr_addr_q[1] !== 6'd1)
            $display("FAIL ignore_start_writes: got count=%0d expected 2 writes 01020304,05060708",
                     wr_data_q.size());
        else n_pass++;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_single_word();
        test_gapped();
        test_bad_csum();
        test_oversize();
        test_reset_mid_word();
        test_empty_restart();
        test_start_ignored();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA, default 32: instruction word width in bits.
REQ-002 Parameter ADDR, default 6: instruction memory address width, giving 64 words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader accepts the byte this cycle; a byte transfers when in_valid and in_ready are both high.
REQ-009 im_we  output  1  instruction memory write strobe, one cycle per word.
REQ-010 im_addr  output  ADDR  instruction memory write address.
REQ-011 im_wdata  output  DATA  instruction memory write data.
REQ-012 cpu_run  output  1  processor release; high only in DONE.
REQ-013 load_done  output  1  load completed with a good checksum; level signal.
REQ-014 load_err  output  1  checksum mismatch; level signal.

Function
REQ-015 FSM states SHALL be IDLE, HDR, DATA, CSUM, WAITW, DONE and ERR.
REQ-016 IDLE/DONE/ERR + start -> HDR. Starting from DONE or ERR clears load_done, load_err, the word counter and the checksum.
REQ-017 in_ready SHALL be high exactly in HDR, DATA and CSUM.
REQ-018 HDR: the accepted byte N is the word count. N=0 -> CSUM. N>64 -> ERR. Otherwise -> DATA.
REQ-019 DATA: bytes are packed MSB first. The 1st byte of a word goes to [31:24] and the 4th byte to [7:0].
REQ-020 On the 4th byte of a word, im_we SHALL pulse high in the next cycle with im_addr = word index (0-based) and im_wdata = the assembled word.
REQ-021 After word N-1 is written, the FSM SHALL move to CSUM. im_addr SHALL never wrap past N-1.
REQ-022 Checksum = 8-bit XOR of the header byte and all data bytes.
REQ-023 CSUM: the accepted byte is compared with the checksum. Equal -> WAITW then DONE. Unequal -> ERR.
REQ-024 WAITW SHALL last exactly 1 cycle so the final im_we has completed before cpu_run rises.
REQ-025 DONE: cpu_run=1 and load_done=1. ERR: load_err=1 and cpu_run=0.
REQ-026 in_valid low stalls the FSM in place with no timeout. Partial-word bytes are held.
REQ-027 start asserted in HDR, DATA or CSUM SHALL be ignored.
REQ-028 im_we SHALL be 0 in every cycle except the cycle after a 4th byte is accepted.
REQ-029 im_addr and im_wdata SHALL hold their last value when im_we=0.

Reset
REQ-030 rst low SHALL immediately force state IDLE and clear every output and internal register to 0, including in_ready, im_we, cpu_run and both flags.
REQ-031 Reset asserted mid-load SHALL discard the partial word. No im_we SHALL issue after reset asserts.
REQ-032 After rst deasserts, the block SHALL stay in IDLE until start.

Structure
REQ-033 Package prog_loader_pkg SHALL hold the state enum, DATA, ADDR, MAX_WORDS=64 and the byte width 8.
REQ-034 Byte-to-word packing (shift register plus 2-bit byte counter) SHALL be a sub-module named word_packer. Its outputs are word and word_valid.
REQ-035 The FSM, word counter and checksum SHALL live in prog_loader.

Verification
REQ-036 Single-word load: start, bytes 01,AA,BB,CC,DD,checksum 01^AA^BB^CC^DD=01, streamed back to back. Required: im_we once with addr 0, data AABBCCDD; cpu_run=1 two cycles after the checksum byte.
REQ-037 Gapped stream: N=3 with in_valid low for 5 cycles between bytes. Required: three writes at addr 0, 1, 2 in order; no extra im_we; load_done=1.
REQ-038 Bad checksum: N=1, correct data, checksum byte 00. Required: load_err=1, cpu_run=0, one im_we issued.
REQ-039 Oversize header: N=65 (0x41). Required: ERR the next cycle, no im_we, in_ready=0.
REQ-040 Reset mid-word: rst low after 2 of 4 data bytes, then release, start, and a valid N=1 load. Required: outputs 0 during reset; exactly one write follows, with the new word.
REQ-041 Empty and restart: N=0 with checksum 00 gives DONE with no im_we. A second start from DONE clears load_done and cpu_run in the next cycle.
